// File: rtl/mac_pkg.sv
// Shared constants and instruction encodings for the MAC array family.
package mac_pkg;

    localparam int BW      = 4;
    localparam int PSUM_BW = 16;
    localparam int ROW     = 8;
    localparam int COL     = 8;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/inst_skew_pipe.sv
// Reset-cleared shift register; every stage is exposed as a tap.
module inst_skew_pipe #(
    parameter int depth = 8,
    parameter int width = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [width-1:0]       din,
    output logic [depth*width-1:0] taps
);

    logic [width-1:0] q [depth];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < depth; d++) q[d] <= '0;
        end else begin
            q[0] <= din;
            for (int d = 1; d < depth; d++) q[d] <= q[d-1];
        end
    end

    for (genvar d = 0; d < depth; d++) begin : g_tap
        assign taps[width*d +: width] = q[d];
    end

endmodule

// File: rtl/mac_row.sv
// One row of weight-stationary MAC tiles; activation and instruction
// ripple east one tile per cycle, psum leaves south from a register.
module mac_row
    import mac_pkg::*;
#(
    parameter int bw      = BW,
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [bw-1:0]          in_w,
    input  logic [1:0]             inst_w,
    input  logic [psum_bw*col-1:0] in_n,
    output logic [psum_bw*col-1:0] out_s,
    output logic [col-1:0]         valid
);

    logic [bw-1:0] a_o [col];
    logic [1:0]    i_o [col];

    for (genvar c = 0; c < col; c++) begin : g_tile
        logic [bw-1:0]      a_in;
        logic [bw-1:0]      a_q;
        logic [bw-1:0]      w_q;
        logic [1:0]         i_in;
        logic [1:0]         i_q;
        logic [psum_bw-1:0] p_q;
        logic               v_q;

        if (c == 0) begin : g_head
            assign a_in = in_w;
            assign i_in = inst_w;
        end else begin : g_body
            assign a_in = a_o[c-1];
            assign i_in = i_o[c-1];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                a_q <= '0;
                i_q <= '0;
                w_q <= '0;
                p_q <= '0;
                v_q <= 1'b0;
            end else begin
                a_q <= a_in;
                i_q <= i_in;
                v_q <= i_in[1];
                if (i_in[0]) w_q <= a_in;
                if (i_in[1])
                    p_q <= in_n[psum_bw*c +: psum_bw]
                         + psum_bw'(a_in) * psum_bw'(w_q);
            end
        end

        assign a_o[c] = a_q;
        assign i_o[c] = i_q;
        assign out_s[psum_bw*c +: psum_bw] = p_q;
        assign valid[c] = v_q;
    end

endmodule

// File: rtl/mac_array_p.sv
// Parametrised row x col weight-stationary MAC array with drain tracking.
// Optional row pruning mask when MAC_ROW_PRUNE_EN is defined.
module mac_array_p
    import mac_pkg::*;
#(
    parameter int bw        = BW,
    parameter int psum_bw   = PSUM_BW,
    parameter int col       = COL,
    parameter int row       = ROW,
    parameter int cnt_bw    = 16,
    parameter int drain_cyc = row + col + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [row*bw-1:0]      in_w,
    input  logic [psum_bw*col-1:0] in_n,
    input  logic [1:0]             inst_w,
`ifdef MAC_ROW_PRUNE_EN
    input  logic [row-1:0]         row_en,
    input  logic                   mask_we,
`endif
    output logic [psum_bw*col-1:0] out_s,
    output logic [col-1:0]         valid,
    output logic                   busy,
    output logic                   done,
    output logic [cnt_bw-1:0]      out_cnt
);

    localparam int DW = $clog2(drain_cyc + 1);

    logic [2*row-1:0]       inst_q;
    logic [row*bw-1:0]      w_eff;
    logic [psum_bw*col-1:0] psum [row+1];
    logic [col-1:0]         row_vld [row];
    logic [DW-1:0]          drain_cnt;

    inst_skew_pipe #(.depth(row), .width(2)) u_skew (
        .clk   (clk),
        .reset (reset),
        .din   (inst_w),
        .taps  (inst_q)
    );

`ifdef MAC_ROW_PRUNE_EN
    logic [row-1:0] row_mask;

    // Mask is frozen while work is in flight so latency stays mask-free.
    always_ff @(posedge clk) begin
        if (reset) row_mask <= '1;
        else if (mask_we && !busy) row_mask <= row_en;
    end

    for (genvar r = 0; r < row; r++) begin : g_mask
        assign w_eff[bw*r +: bw] = row_mask[r] ? in_w[bw*r +: bw] : '0;
    end
`else
    assign w_eff = in_w;
`endif

    assign psum[0] = in_n;

    for (genvar r = 0; r < row; r++) begin : g_row
        mac_row #(.bw(bw), .psum_bw(psum_bw), .col(col)) u_row (
            .clk    (clk),
            .reset  (reset),
            .in_w   (w_eff[bw*r +: bw]),
            .inst_w (inst_q[2*r +: 2]),
            .in_n   (psum[r]),
            .out_s  (psum[r+1]),
            .valid  (row_vld[r])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_s   <= '0;
            valid   <= '0;
            out_cnt <= '0;
        end else begin
            out_s   <= psum[row];
            valid   <= row_vld[row-1];
            out_cnt <= out_cnt + cnt_bw'(row_vld[row-1][col-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            if (inst_w != INST_IDLE) drain_cnt <= DW'(drain_cyc);
            else if (drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
            done <= (drain_cnt == DW'(1)) && (inst_w == INST_IDLE);
        end
    end

    assign busy = (drain_cnt != '0);

endmodule

// File: doc/mac_array_p.md
# mac_array_p

Parametrised successor of the 2-D weight-stationary MAC array. It instantiates a `row` × `col` grid of existing `mac_row` instances and replaces the fixed 8-stage instruction skew with a `row`-deep, reset-cleared skew pipe. It adds a registered output stage, a drain/busy tracker with a done pulse, an output-vector counter, and optional row pruning. It sits between the L0/IFIFO feeders (west and north) and the OFIFO (south) in each core.

## Interface
- `bw`, default 4: activation/weight width.
- `psum_bw`, default 16: partial-sum width.
- `col`, default 8: columns.
- `row`, default 8: rows.
- `cnt_bw`, default 16: `out_cnt` width.
- `drain_cyc`, default `row+col+1`: cycles to keep `busy` high after the last non-zero instruction.
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_w` in `row*bw`: west inputs; row r is on bits `[bw*(r+1)-1 : bw*r]`.
- `in_n` in `psum_bw*col`: north psum injected into row 0.
- `inst_w` in 2: bit1 = execute, bit0 = kernel load.
- `row_en` in `row`: pruning mask, present only with the macro. Bit = 1 means the row is active.
- `mask_we` in 1: mask write strobe, present only with the macro.
- `out_s` out `psum_bw*col`: registered south psums.
- `valid` out `col`: registered per-column valid.
- `busy` out 1: array holds in-flight instructions.
- `done` out 1: one-cycle pulse when `busy` falls.
- `out_cnt` out `cnt_bw`: count of `valid[col-1]` pulses since reset.

## Operation
- **Skew pipe.** `inst_q[0] <= inst_w`, and `inst_q[r] <= inst_q[r-1]` for r = 1..row-1. Row r receives `inst_q[r]`, i.e. `inst_w` delayed by r+1 cycles. Generate-based for any `row` ≥ 1.
- **Psum chain.**
  - Row 0 `in_n` = port `in_n`.
  - Row r `in_n` = row r-1 `out_s`.
  - Last row `out_s` and `valid` feed the output stage.
- **Output stage.** `out_s <= last_row.out_s` and `valid <= last_row.valid` every cycle.
- **Drain tracker.**
  - `drain_cnt` loads `drain_cyc` on any cycle with `inst_w != 2'b00`.
  - Otherwise it decrements when non-zero.
  - `busy = (drain_cnt != 0)`.
  - `done` is high for exactly one cycle, the cycle after `drain_cnt` goes 1→0. It does not fire if a reload occurs on that edge.
- **Counter.** `out_cnt` increments on each cycle with `valid[col-1] == 1` and wraps modulo 2^`cnt_bw`.
- **Simultaneous events.** A new instruction on the cycle `drain_cnt` would reach 0 reloads the counter. `busy` stays high and no `done` is issued.
- **Reset mid-operation.** All skew stages go to 00, `drain_cnt` to 0, `out_s`, `valid`, `done` and `out_cnt` to 0, and `busy` to 0. Tile weights are cleared by `mac_row`'s own reset.

## Timing
- Instruction reaches row r after r+1 cycles.
- Output stage adds 1 cycle over the unregistered array: `valid`/`out_s` appear 1 cycle after the last row produces them.
- Column c's valid lags column 0's by c cycles (tile skew).
- `busy` rises the cycle after the first non-zero `inst_w`.
- `busy` falls exactly `drain_cyc` cycles after the last non-zero `inst_w`; `done` pulses on the same cycle it falls.
- Reset values of all outputs are 0.

## Configuration
- Macro: `MAC_ROW_PRUNE_EN`.
- **Defined.**
  - `row_en` and `mask_we` exist, with a `row`-bit `row_mask` register (reset = all 1).
  - `row_mask <= row_en` on `mask_we` only when `busy == 0`. A write while busy is ignored.
  - A masked row (mask bit 0) gets its `in_w` forced to 0, so it loads zero weights and adds 0.
  - Skew and timing are unchanged, so latency does not depend on the mask.
- **Undefined.**
  - Ports absent, no mask register.
  - `in_w` passes straight through.

## Structure
- Shared package `mac_pkg` holds:
  - the default constants (`BW`, `PSUM_BW`, `ROW`, `COL`);
  - the instruction encodings `INST_IDLE=2'b00`, `INST_LOAD=2'b01`, `INST_EXEC=2'b10`.
- Sub-module `inst_skew_pipe` (params `depth`, `width`): synchronous-reset shift register with all taps exposed. This block uses it with `depth=row`, `width=2`.
- `mac_row` is reused unchanged.

## Test plan
All scenarios use row=col=8, bw=4, psum_bw=16, macro on unless noted.
1. **Reset.**
   - Stimulus: hold `reset` 3 cycles with random inputs.
   - Required: `out_s=0`, `valid=0`, `busy=0`, `done=0`, `out_cnt=0`, all skew taps 00.
2. **Skew.**
   - Stimulus: single-cycle `inst_w=01`.
   - Required: row r sees 01 exactly r+1 cycles later.
   - Required: `busy` high for 17 cycles (`drain_cyc`=17), then `done` pulses once.
3. **Compute.**
   - Stimulus: load all weights = 1, then execute 4 vectors with all activations = 1 and `in_n=0`.
   - Required: every column's `out_s` = 8 on its valid cycles.
   - Required: `out_cnt` = 4 after drain; `valid[c]` trails `valid[0]` by c cycles.
4. **Pruning.**
   - Stimulus: `row_en=8'b0000_1111` written while idle, then the scenario 3 stimulus.
   - Required: each column = 4, with identical valid timing.
   - Stimulus: a `mask_we` issued while busy.
   - Required: `row_mask` unchanged.
5. **Reload at boundary and reset mid-run.**
   - Stimulus: new `inst_w=10` on the cycle `drain_cnt`=1.
   - Required: no `done` pulse; `busy` continues.
   - Stimulus: `reset` mid-execute.
   - Required: all outputs 0 next cycle, and `busy` stays 0 until a new instruction is issued.
6. **Macro off.**
   - Stimulus: scenario 3 compiled without the macro.
   - Required: identical results.
   - Stimulus: `out_cnt` wrap at `cnt_bw`=4.
   - Required: counts 15→0.
